dj_alu_exec: RTL and testbench

Execute stage directly downstream of the control decoder. Consumes the decoded 8-bit ALU command and the regwrite strobe, operates on two register operands, and produces a registered result with a writeback enable and address. Holds architectural state that needs sequential logic: carry flag, zero flag and the loop counter register. MUL uses an iterative shift-add sequence.

---
 rtl/dj_alu_pkg.sv | 33 +++
 rtl/dj_alu_exec_mul.sv | 58 +++++
 rtl/dj_alu_exec.sv | 210 +++++++++++++++++++++
 tb/tb_dj_alu_exec.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dj_alu_pkg.sv
// Shared opcode values, FSM state encoding and opcode helper for the
// dj_alu_exec execute stage.
package dj_alu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_NOT  = 8'h06;
    localparam logic [7:0] OP_XOR  = 8'h07;
    localparam logic [7:0] OP_SHL  = 8'h08;
    localparam logic [7:0] OP_SHR  = 8'h09;
    localparam logic [7:0] OP_GT   = 8'h0A;
    localparam logic [7:0] OP_LT   = 8'h0B;
    localparam logic [7:0] OP_EQ   = 8'h0C;
    localparam logic [7:0] OP_CSET = 8'h0D;
    localparam logic [7:0] OP_CINC = 8'h0E;
    localparam logic [7:0] OP_CDEC = 8'h0F;
    localparam logic [7:0] OP_ADC  = 8'h10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Anything outside 0x01..0x10 behaves as NOP (no flags, no writeback).
    function automatic logic op_known(input logic [7:0] op);
        return (op != OP_NOP) && (op <= OP_ADC);
    endfunction

endpackage

// File: rtl/dj_alu_exec_mul.sv
// dj_mul_seq: iterative shift-add multiplier, one partial product per clock.
// start_i loads the operands; the next DATA_W clocks each add one partial
// product. done_o is high during the last iteration and product_o then carries
// the final (combinational) sum so the caller can register it on that edge.
module dj_mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic                busy_q;
    logic [CW-1:0]       cnt_q;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;

    // Accumulate the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
    end

    // Operand load on start, then one shift-add step per clock while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST) busy_q <= 1'b0;
        end
    end

    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = acc_d;

endmodule

// File: rtl/dj_alu_exec.sv
// dj_alu_exec: execute stage behind the control decoder. Registered result,
// writeback enable/address, carry/zero flags and loop counter.
// Build option ALU_MUL_1CYC_EN: when defined, MUL is a single-cycle
// combinational multiply and the iterative multiplier/FSM are left out.
module dj_alu_exec
    import dj_alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        alu_control_command,
    input  logic              regwrite_control,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [ADDR_W-1:0] wb_addr_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              flag_carry,
    output logic              flag_zero,
    output logic [DATA_W-1:0] counter_value
);

    localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

    logic              accept;
    logic              known;
    logic              defer;      // op completes later (iterative MUL)
    logic [DATA_W-1:0] op_res;
    logic              op_carry;
    logic              upd_carry;
    logic [DATA_W-1:0] cnt_next;
    logic [DATA_W:0]   sum_add;
    logic [DATA_W:0]   sum_adc;

    logic              out_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              wb_en_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              carry_q;
    logic              zero_q;
    logic [DATA_W-1:0] counter_q;

    assign accept = in_valid && in_ready;
    assign known  = op_known(alu_control_command);

`ifdef ALU_MUL_1CYC_EN
    logic [2*DATA_W-1:0] mul_full;
    assign mul_full = operand_a * operand_b;
    assign defer    = 1'b0;
    assign in_ready = 1'b1;
`else
    state_e              state_q, state_d;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_prod;
    logic                pend_wb_en_q;
    logic [ADDR_W-1:0]   pend_wb_addr_q;

    assign mul_start = accept && (alu_control_command == OP_MUL);
    assign defer     = mul_start;

    dj_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (operand_a),
        .b_i       (operand_b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake: stall the input for the whole multiply.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (mul_start) state_d = ST_MUL;
            end
            ST_MUL: begin
                if (mul_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold the writeback target of an in-flight multiply until it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_wb_en_q   <= 1'b0;
            pend_wb_addr_q <= '0;
        end else if (mul_start) begin
            pend_wb_en_q   <= regwrite_control;
            pend_wb_addr_q <= wb_addr_in;
        end
    end
`endif

    // Single-cycle datapath: result, carry candidate and next counter value.
    always_comb begin
        sum_add   = {1'b0, operand_a} + {1'b0, operand_b};
        sum_adc   = sum_add + (DATA_W+1)'(carry_q);
        op_res    = '0;
        op_carry  = carry_q;
        upd_carry = 1'b0;
        cnt_next  = counter_q;
        case (alu_control_command)
            OP_ADD: begin
                op_res    = sum_add[DATA_W-1:0];
                op_carry  = sum_add[DATA_W];
                upd_carry = 1'b1;
            end
            OP_SUB: begin
                op_res    = operand_a - operand_b;
                op_carry  = operand_a < operand_b;
                upd_carry = 1'b1;
            end
`ifdef ALU_MUL_1CYC_EN
            OP_MUL: begin
                op_res    = mul_full[DATA_W-1:0];
                op_carry  = |mul_full[2*DATA_W-1:DATA_W];
                upd_carry = 1'b1;
            end
`endif
            OP_AND:  op_res = operand_a & operand_b;
            OP_OR:   op_res = operand_a | operand_b;
            OP_NOT:  op_res = ~operand_a;
            OP_XOR:  op_res = operand_a ^ operand_b;
            OP_SHL:  op_res = (operand_b >= SH_LIM) ? '0 : operand_a << operand_b;
            OP_SHR:  op_res = (operand_b >= SH_LIM) ? '0 : operand_a >> operand_b;
            OP_GT:   op_res = {{(DATA_W-1){1'b0}}, operand_a > operand_b};
            OP_LT:   op_res = {{(DATA_W-1){1'b0}}, operand_a < operand_b};
            OP_EQ:   op_res = {{(DATA_W-1){1'b0}}, operand_a == operand_b};
            OP_CSET: begin
                cnt_next = operand_a;
                op_res   = operand_a;
            end
            OP_CINC: begin
                cnt_next = counter_q + DATA_W'(1);
                op_res   = cnt_next;
            end
            OP_CDEC: begin
                cnt_next = counter_q - DATA_W'(1);
                op_res   = cnt_next;
            end
            OP_ADC: begin
                op_res    = sum_adc[DATA_W-1:0];
                op_carry  = sum_adc[DATA_W];
                upd_carry = 1'b1;
            end
            default: op_res = '0;
        endcase
    end

    // Output, flag and counter registers; out_valid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            counter_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && !defer) begin
                out_valid_q <= 1'b1;
                result_q    <= op_res;
                wb_en_q     <= regwrite_control && known;
                wb_addr_q   <= wb_addr_in;
                counter_q   <= cnt_next;
                if (known)     zero_q  <= (op_res == '0);
                if (upd_carry) carry_q <= op_carry;
            end
`ifndef ALU_MUL_1CYC_EN
            if (mul_done) begin
                out_valid_q <= 1'b1;
                result_q    <= mul_prod[DATA_W-1:0];
                carry_q     <= |mul_prod[2*DATA_W-1:DATA_W];
                zero_q      <= (mul_prod[DATA_W-1:0] == '0);
                wb_en_q     <= pend_wb_en_q;
                wb_addr_q   <= pend_wb_addr_q;
            end
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign wb_en         = wb_en_q;
    assign wb_addr       = wb_addr_q;
    assign flag_carry    = carry_q;
    assign flag_zero     = zero_q;
    assign counter_value = counter_q;

endmodule

// File: tb/tb_dj_alu_exec.sv
// Self-checking bench for dj_alu_exec: directed cases plus a randomized
// stream compared against an integer-arithmetic reference model.
module tb_dj_alu_exec;

    localparam int  DW   = 16;
    localparam int  AW   = 4;
    localparam longint M = 64'hFFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    cmd;
    logic          rw;
    logic [DW-1:0] opa, opb;
    logic [AW-1:0] waddr;
    logic          out_valid;
    logic [DW-1:0] result;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic          flag_carry, flag_zero;
    logic [DW-1:0] counter_value;

    int checks   = 0;
    int failures = 0;

    // reference model state
    longint m_carry, m_zero, m_cnt;

    always #5 clk = ~clk;

    dj_alu_exec #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .alu_control_command (cmd),
        .regwrite_control    (rw),
        .operand_a           (opa),
        .operand_b           (opb),
        .wb_addr_in          (waddr),
        .out_valid           (out_valid),
        .result              (result),
        .wb_en               (wb_en),
        .wb_addr             (wb_addr),
        .flag_carry          (flag_carry),
        .flag_zero           (flag_zero),
        .counter_value       (counter_value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: updates flags/counter, returns expected result.
    task automatic model_op(input int op, input longint a, input longint b, output longint r);
        longint s;
        bit known;
        known = (op >= 1 && op <= 16);
        r = 0;
        case (op)
            1:  begin s = a + b;           r = s & M; m_carry = (s > M); end
            2:  begin r = (a - b) & M;     m_carry = (a < b); end
            3:  begin s = a * b;           r = s & M; m_carry = ((s >> 16) != 0); end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = (~a) & M;
            7:  r = a ^ b;
            8:  r = (b >= DW) ? 0 : ((a << b) & M);
            9:  r = (b >= DW) ? 0 : (a >> b);
            10: r = (a > b)  ? 1 : 0;
            11: r = (a < b)  ? 1 : 0;
            12: r = (a == b) ? 1 : 0;
            13: begin m_cnt = a;                r = m_cnt; end
            14: begin m_cnt = (m_cnt + 1) & M;  r = m_cnt; end
            15: begin m_cnt = (m_cnt - 1) & M;  r = m_cnt; end
            16: begin s = a + b + m_carry;  r = s & M; m_carry = (s > M); end
            default: r = 0;
        endcase
        if (known) m_zero = (r == 0) ? 1 : 0;
    endtask

    // Issue one command, wait for its result and compare everything.
    task automatic do_op(input int op, input longint a, input longint b,
                         input bit wr, input int addr, input bit noise);
        longint er;
        int     lat, exp_lat;
        bit     seen, exp_wb;
        @(negedge clk);
        chk("ov_idle", out_valid, 1'b0);
        chk("ready_pre", in_ready, 1'b1);
        in_valid = 1'b1;
        cmd      = op[7:0];
        opa      = a[DW-1:0];
        opb      = b[DW-1:0];
        rw       = wr;
        waddr    = addr[AW-1:0];
        model_op(op, a, b, er);
        exp_lat = (op == 3) ? DW : 0;
        exp_wb  = wr && (op >= 1 && op <= 16);
        @(posedge clk);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen     = 1'b1;
                in_valid = 1'b0;
            end else begin
                chk("ready_busy", in_ready, 1'b0);
                in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                cmd      = 8'($urandom_range(0, 20));
                opa      = 16'($urandom);
                opb      = 16'($urandom);
                rw       = 1'($urandom);
                waddr    = 4'($urandom);
                @(posedge clk);
                lat++;
            end
        end
        in_valid = 1'b0;
        chk($sformatf("seen_op%0h", op), seen, 1'b1);
        if (seen) begin
            chk($sformatf("lat_op%0h", op), lat, exp_lat);
            chk($sformatf("res_op%0h", op), result, er[31:0]);
            chk("carry", flag_carry, m_carry[0]);
            chk("zero", flag_zero, m_zero[0]);
            chk("counter", counter_value, m_cnt[31:0]);
            chk("wb_en", wb_en, exp_wb);
            chk("wb_addr", wb_addr, addr);
            chk("ready_post", in_ready, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; cmd = '0; rw = 1'b0;
        opa = '0; opb = '0; waddr = '0;
        m_carry = 0; m_zero = 0; m_cnt = 0;
        #1;
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_res", result, 0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_flags", {flag_carry, flag_zero, wb_en}, 0);
        chk("rst_cnt", counter_value, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // add / adc carry chain
        do_op(1, 16'hFFFF, 1, 1, 3, 0);
        chk("add_res", result, 16'h0000);
        chk("add_cz", {flag_carry, flag_zero}, 2'b11);
        do_op(16, 1, 1, 1, 5, 0);
        chk("adc_res", result, 16'h0003);
        chk("adc_c", flag_carry, 1'b0);

        // multiply with ignored input noise
        do_op(3, 16'h0012, 16'h0034, 1, 7, 1);
        chk("mul_res", result, 16'h03A8);
        chk("mul_c", flag_carry, 1'b0);
        do_op(3, 16'h0100, 16'h0100, 0, 9, 1);
        chk("mul_ovf", {flag_carry, flag_zero}, 2'b11);

        // loop counter wrap
        do_op(13, 16'hFFFE, 0, 1, 1, 0);
        do_op(14, 0, 0, 1, 1, 0);
        chk("inc1", result, 16'hFFFF);
        do_op(14, 0, 0, 1, 1, 0);
        chk("inc2", result, 16'h0000);
        chk("inc2_z", flag_zero, 1'b1);
        do_op(15, 0, 0, 1, 1, 0);
        chk("dec", counter_value, 16'hFFFF);

        // shifts and compares
        do_op(8, 1, 4, 1, 2, 0);
        chk("shl", result, 16'h0010);
        do_op(9, 16'h8000, 16, 1, 2, 0);
        chk("shr16", result, 16'h0000);
        do_op(10, 5, 3, 1, 2, 0);
        chk("gt", result, 1);
        do_op(11, 5, 3, 1, 2, 0);
        chk("lt", result, 0);
        do_op(12, 7, 7, 1, 2, 0);
        chk("eq", result, 1);

        // NOP after a carry-setting add
        do_op(1, 16'hFFFF, 2, 1, 4, 0);
        do_op(0, 16'h1234, 16'h5678, 0, 6, 0);
        chk("nop_res", result, 0);
        chk("nop_wb", wb_en, 1'b0);
        chk("nop_c", flag_carry, 1'b1);

        // reset in the fifth multiply cycle
        @(negedge clk);
        in_valid = 1'b1; cmd = 8'h03; opa = 16'h00FF; opb = 16'h00FF; rw = 1'b1; waddr = 4'hA;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        m_carry = 0; m_zero = 0; m_cnt = 0;
        chk("abort_ov", out_valid, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_out", {result, wb_en, wb_addr, flag_carry, flag_zero}, 0);
        chk("abort_cnt", counter_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_ov", out_valid, 1'b0);
        end
        do_op(1, 2, 3, 1, 8, 0);
        chk("post_add", result, 16'h0005);
        chk("post_c", flag_carry, 1'b0);

        // randomized stream including unknown opcodes
        for (int i = 0; i < 120; i++) begin
            int     op;
            longint a, b;
            op = $urandom_range(0, 20);
            a  = $urandom_range(0, 65535);
            b  = $urandom_range(0, 65535);
            if ((op == 8 || op == 9) && $urandom_range(0, 3) != 0) b = $urandom_range(0, 20);
            if (op >= 10 && op <= 12 && $urandom_range(0, 2) == 0) b = a;
            do_op(op, a, b, 1'($urandom), $urandom_range(0, 15), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
